// File: rtl/dut_system_pkg.sv
// Shared defaults and helpers for the streaming wrapper.
// Imported by the interface, FIFO and top.
package dut_system_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 64;

  // Occupancy counter must reach depth itself, hence the extra bit.
  function automatic int unsigned cnt_w(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dut_system_if.sv
// FIFO access bundle: push side, pop side and status flags.
// master drives requests, slave is the FIFO.
interface dut_system_if
  import dut_system_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic          wr_en;
  logic [DW-1:0] din;
  logic          full;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;

  modport master (
    output wr_en,
    output din,
    output rd_en,
    input  full,
    input  dout,
    input  empty
  );

  modport slave (
    input  wr_en,
    input  din,
    input  rd_en,
    output full,
    output dout,
    output empty
  );

endinterface

// File: rtl/dut_system_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty.
// dout reads the head slot combinationally, zero while empty.
module dut_system_fifo
  import dut_system_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH  = DW_DEF,
  parameter int unsigned FIFO_BUFFER_SIZE = DEPTH_DEF
) (
  input  logic         clock,
  input  logic         reset,
  dut_system_if.slave  port
);

  localparam int unsigned PW = $clog2(FIFO_BUFFER_SIZE);
  localparam int unsigned CW = cnt_w(FIFO_BUFFER_SIZE);

  logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_BUFFER_SIZE];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push, pop;

  assign push = port.wr_en && !full_q;
  assign pop  = port.rd_en && !empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CW'(FIFO_BUFFER_SIZE));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: dout is masked until a word lands.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wptr_q] <= port.din;
    end
  end

  assign port.dout  = empty_q ? '0 : mem_q[rptr_q];
  assign port.full  = full_q;
  assign port.empty = empty_q;

endmodule

// File: rtl/dut_system.sv
// Streaming wrapper: input FIFO -> identity transfer -> output FIFO.
// Transfer moves one word per clock with no staging register.
module dut_system
  import dut_system_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH  = DW_DEF,
  parameter int unsigned FIFO_BUFFER_SIZE = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_in_din,
  input  logic                       fifo_in_wr_en,
  output logic                       fifo_in_full,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_out_dout,
  input  logic                       fifo_out_rd_en,
  output logic                       fifo_out_empty
);

  dut_system_if #(.DW(FIFO_DATA_WIDTH)) in_if ();
  dut_system_if #(.DW(FIFO_DATA_WIDTH)) out_if ();

  logic xfer;

  assign in_if.wr_en = fifo_in_wr_en;
  assign in_if.din   = fifo_in_din;
  assign fifo_in_full = in_if.full;

  // Later per-word stages slot in between in_if.dout and out_if.din.
  assign xfer         = !in_if.empty && !out_if.full;
  assign in_if.rd_en  = xfer;
  assign out_if.wr_en = xfer;
  assign out_if.din   = in_if.dout;

  assign out_if.rd_en   = fifo_out_rd_en;
  assign fifo_out_dout  = out_if.dout;
  assign fifo_out_empty = out_if.empty;

  dut_system_fifo #(
    .FIFO_DATA_WIDTH  (FIFO_DATA_WIDTH),
    .FIFO_BUFFER_SIZE (FIFO_BUFFER_SIZE)
  ) fifo_in_inst (
    .clock (clock),
    .reset (reset),
    .port  (in_if.slave)
  );

  dut_system_fifo #(
    .FIFO_DATA_WIDTH  (FIFO_DATA_WIDTH),
    .FIFO_BUFFER_SIZE (FIFO_BUFFER_SIZE)
  ) fifo_out_inst (
    .clock (clock),
    .reset (reset),
    .port  (out_if.slave)
  );

endmodule

// File: tb/tb_dut_system.sv
// Directed bench for dut_system: latency, backpressure, wrap, reset.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_dut_system;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  dut_system_if #(.DW(32)) bus ();

  dut_system #(
    .FIFO_DATA_WIDTH  (32),
    .FIFO_BUFFER_SIZE (64)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_din    (bus.din),
    .fifo_in_wr_en  (bus.wr_en),
    .fifo_in_full   (bus.full),
    .fifo_out_dout  (bus.dout),
    .fifo_out_rd_en (bus.rd_en),
    .fifo_out_empty (bus.empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.empty !== 1'b1) begin
        failures++;
        $display("FAIL rst_empty cyc=%0d got=%b exp=1", i, bus.empty);
      end
      checks++;
      if (bus.full !== 1'b0) begin
        failures++;
        $display("FAIL rst_full cyc=%0d got=%b exp=0", i, bus.full);
      end
      checks++;
      if (bus.dout !== 32'h0) begin
        failures++;
        $display("FAIL rst_dout cyc=%0d got=%h exp=0", i, bus.dout);
      end
    end
  endtask

  task automatic test_stream();
    int first;
    int last;
    int got;
    first = -1;
    last  = -1;
    got   = 0;
    bus.rd_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c < 16) begin
        bus.wr_en = 1'b1;
        bus.din   = 32'(c + 1);
      end else begin
        bus.wr_en = 1'b0;
      end
      tick();
      if (!bus.empty) begin
        checks++;
        if (bus.dout !== 32'(got + 1)) begin
          failures++;
          $display("FAIL stream_data got=%h exp=%h", bus.dout, 32'(got + 1));
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    bus.wr_en = 1'b0;
    checks++;
    if (first !== 1) begin
      failures++;
      $display("FAIL stream_first_cycle got=%0d exp=1", first);
    end
    checks++;
    if (last !== 16) begin
      failures++;
      $display("FAIL stream_last_cycle got=%0d exp=16", last);
    end
    checks++;
    if (got !== 16) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=16", got);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int full_at;
    int got;
    acc     = 0;
    full_at = -1;
    got     = 0;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus.wr_en = 1'b1;
      bus.din   = 32'(i + 1);
      if (!bus.full) acc++;
      else if (full_at < 0) full_at = acc;
      tick();
    end
    bus.wr_en = 1'b0;
    checks++;
    if (acc !== 128) begin
      failures++;
      $display("FAIL bp_accepted got=%0d exp=128", acc);
    end
    checks++;
    if (full_at !== 128) begin
      failures++;
      $display("FAIL bp_full_point got=%0d exp=128", full_at);
    end
    checks++;
    if (bus.full !== 1'b1) begin
      failures++;
      $display("FAIL bp_full_held got=%b exp=1", bus.full);
    end
    bus.rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!bus.empty) begin
        checks++;
        if (bus.dout !== 32'(got + 1)) begin
          failures++;
          $display("FAIL bp_drain got=%h exp=%h", bus.dout, 32'(got + 1));
        end
        got++;
      end
      tick();
    end
    bus.rd_en = 1'b0;
    checks++;
    if (got !== 128) begin
      failures++;
      $display("FAIL bp_drain_count got=%0d exp=128", got);
    end
    checks++;
    if (bus.full !== 1'b0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL bp_final full=%b empty=%b exp=0/1", bus.full, bus.empty);
    end
  endtask

  task automatic test_underflow();
    int n;
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.empty !== 1'b1 || bus.dout !== 32'h0) begin
        failures++;
        $display("FAIL uf_idle empty=%b dout=%h exp=1/0", bus.empty, bus.dout);
      end
    end
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.din   = 32'hDEADBEEF;
    tick();
    bus.wr_en = 1'b0;
    n = 0;
    while (bus.empty && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1) begin
      failures++;
      $display("FAIL uf_latency got=%0d exp=1", n);
    end
    checks++;
    if (bus.dout !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL uf_dout got=%h exp=deadbeef", bus.dout);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL uf_pop_empty got=%b exp=1", bus.empty);
    end
  endtask

  task automatic test_wrap();
    int tx;
    int rx;
    int guard;
    tx    = 0;
    rx    = 0;
    guard = 0;
    while (rx < 1000 && guard < 20000) begin
      bus.rd_en = !bus.empty && ($urandom_range(0, 3) != 0);
      if (bus.rd_en) begin
        checks++;
        if (bus.dout !== 32'(rx + 1)) begin
          failures++;
          $display("FAIL wrap_data idx=%0d got=%h exp=%h",
                   rx, bus.dout, 32'(rx + 1));
        end
        rx++;
      end
      if (tx < 1000 && ($urandom_range(0, 3) != 0)) begin
        bus.wr_en = 1'b1;
        bus.din   = 32'(tx + 1);
        if (!bus.full) tx++;
      end else begin
        bus.wr_en = 1'b0;
      end
      tick();
      guard++;
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (rx !== 1000) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=1000", rx);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    got = 0;
    bus.rd_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1;
      bus.din   = 32'(100 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL rm_loaded empty=%b exp=0", bus.empty);
    end
    reset     = 1'b1;
    bus.wr_en = 1'b1;
    bus.din   = 32'h12345678;
    bus.rd_en = 1'b1;
    tick();
    reset     = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL rm_flags empty=%b full=%b exp=1/0", bus.empty, bus.full);
    end
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL rm_dout got=%h exp=0", bus.dout);
    end
    bus.wr_en = 1'b1;
    bus.din   = 32'hA5A5A5A5;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!bus.empty) begin
        checks++;
        if (bus.dout !== 32'hA5A5A5A5) begin
          failures++;
          $display("FAIL rm_data got=%h exp=a5a5a5a5", bus.dout);
        end
        got++;
      end
      tick();
    end
    bus.rd_en = 1'b0;
    checks++;
    if (got !== 1) begin
      failures++;
      $display("FAIL rm_count got=%0d exp=1", got);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
